// File: rtl/retention_ctrl_pkg.sv
// Shared types for the retention power controller.
// States, output bundle, decode and counter sizing.
package retention_ctrl_pkg;

  typedef enum logic [3:0] {
    RUN,
    ISOLATE,
    SAVE,
    CLK_GATE,
    PWR_DOWN,
    SLEEP,
    PWR_UP,
    SETTLE,
    CLK_UNGATE,
    RESTORE,
    DEISO,
    FAULT
  } pwr_state_t;

  typedef struct packed {
    logic pwr_en;
    logic iso_en;
    logic clk_en;
    logic save;
    logic restore;
    logic domain_rst_n;
    logic busy;
    logic asleep;
    logic fault;
  } pwr_out_t;

  localparam pwr_out_t OUT_RESET = '{
    pwr_en: 1'b1, iso_en: 1'b0, clk_en: 1'b1,
    save: 1'b0, restore: 1'b0, domain_rst_n: 1'b0,
    busy: 1'b0, asleep: 1'b0, fault: 1'b0
  };

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic pwr_out_t decode(
    input pwr_state_t s
  );
    pwr_out_t o;
    o = '0;
    unique case (s)
      RUN: begin
        o.pwr_en = 1'b1;
        o.clk_en = 1'b1;
        o.domain_rst_n = 1'b1;
      end
      ISOLATE, CLK_UNGATE, DEISO: begin
        o.pwr_en = 1'b1;
        o.iso_en = 1'b1;
        o.clk_en = 1'b1;
        o.domain_rst_n = 1'b1;
      end
      SAVE: begin
        o.pwr_en = 1'b1;
        o.iso_en = 1'b1;
        o.clk_en = 1'b1;
        o.save = 1'b1;
        o.domain_rst_n = 1'b1;
      end
      CLK_GATE: begin
        o.pwr_en = 1'b1;
        o.iso_en = 1'b1;
        o.domain_rst_n = 1'b1;
      end
      PWR_DOWN: begin
        o.iso_en = 1'b1;
      end
      SLEEP: begin
        o.iso_en = 1'b1;
        o.asleep = 1'b1;
      end
      PWR_UP, SETTLE: begin
        o.pwr_en = 1'b1;
        o.iso_en = 1'b1;
      end
      RESTORE: begin
        o.pwr_en = 1'b1;
        o.iso_en = 1'b1;
        o.clk_en = 1'b1;
        o.restore = 1'b1;
        o.domain_rst_n = 1'b1;
      end
      FAULT: begin
        o.iso_en = 1'b1;
        o.fault = 1'b1;
      end
      default: o = OUT_RESET;
    endcase
    o.busy = !(s inside {RUN, SLEEP, FAULT});
    return o;
  endfunction

endpackage

// File: rtl/retention_power_controller_timer.sv
// Loadable down-counter shared by all timed states.
// Saturates at zero; flags expose zero and one.
module retention_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/retention_power_controller.sv
// Save/restore power sequencer for one switchable domain.
// Moore outputs registered from the next state.
module retention_power_controller
  import retention_ctrl_pkg::*;
#(
  parameter int SAVE_CYCLES    = 2,
  parameter int RESTORE_CYCLES = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sleep_req,
  input  logic wake_req,
  input  logic pwr_ack,
  output logic pwr_en,
  output logic iso_en,
  output logic save,
  output logic restore,
  output logic clk_en,
  output logic domain_rst_n,
  output logic busy,
  output logic asleep,
  output logic fault
);

  localparam int W = cnt_width(
    SAVE_CYCLES, RESTORE_CYCLES,
    SETTLE_CYCLES, ACK_TIMEOUT
  );

  pwr_state_t state;
  pwr_state_t nxt;
  pwr_out_t   outs;

  logic         t_load;
  logic         t_dec;
  logic [W-1:0] t_value;
  logic         t_zero;
  logic         t_one;

  retention_seq_timer #(
    .W(W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (t_load),
    .dec  (t_dec),
    .value(t_value),
    .zero (t_zero),
    .one  (t_one)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      RUN:        if (sleep_req) nxt = ISOLATE;
      ISOLATE:    nxt = SAVE;
      SAVE:       if (t_one) nxt = CLK_GATE;
      CLK_GATE:   nxt = PWR_DOWN;
      PWR_DOWN: begin
        if (!pwr_ack) nxt = SLEEP;
        else if (t_zero) nxt = FAULT;
      end
      SLEEP:      if (wake_req) nxt = PWR_UP;
      PWR_UP: begin
        if (pwr_ack) nxt = SETTLE;
        else if (t_zero) nxt = FAULT;
      end
      // Losing power while settling is fatal.
      SETTLE: begin
        if (!pwr_ack) nxt = FAULT;
        else if (t_one) nxt = CLK_UNGATE;
      end
      CLK_UNGATE: nxt = RESTORE;
      RESTORE:    if (t_one) nxt = DEISO;
      DEISO:      nxt = RUN;
      FAULT:      if (wake_req) nxt = PWR_UP;
      default:    nxt = RUN;
    endcase
  end

  // Timeouts load one less so they expire on zero.
  always_comb begin
    t_load  = (nxt != state);
    t_dec   = 1'b1;
    t_value = '0;
    unique case (nxt)
      SAVE:     t_value = W'(SAVE_CYCLES);
      RESTORE:  t_value = W'(RESTORE_CYCLES);
      SETTLE:   t_value = W'(SETTLE_CYCLES);
      PWR_DOWN,
      PWR_UP:   t_value = W'(ACK_TIMEOUT - 1);
      default:  t_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      outs  <= OUT_RESET;
    end else begin
      state <= nxt;
      outs  <= decode(nxt);
    end
  end

  assign pwr_en       = outs.pwr_en;
  assign iso_en       = outs.iso_en;
  assign save         = outs.save;
  assign restore      = outs.restore;
  assign clk_en       = outs.clk_en;
  assign domain_rst_n = outs.domain_rst_n;
  assign busy         = outs.busy;
  assign asleep       = outs.asleep;
  assign fault        = outs.fault;

endmodule

// File: tb/tb_retention_power_controller.sv
// Directed scoreboard bench for the retention controller.
// Default instance plus a SAVE=1/RESTORE=5/SETTLE=1 instance.
module tb_retention_power_controller;

  // {pwr_en,iso_en,clk_en,save,restore,drst_n,busy,asleep,fault}
  localparam logic [8:0] E_RST = 9'b101000_000;
  localparam logic [8:0] E_RUN = 9'b101001_000;
  localparam logic [8:0] E_ISO = 9'b111001_100;
  localparam logic [8:0] E_SAV = 9'b111101_100;
  localparam logic [8:0] E_CG  = 9'b110001_100;
  localparam logic [8:0] E_PD  = 9'b010000_100;
  localparam logic [8:0] E_SLP = 9'b010000_010;
  localparam logic [8:0] E_PU  = 9'b110000_100;
  localparam logic [8:0] E_ST  = 9'b110000_100;
  localparam logic [8:0] E_CU  = 9'b111001_100;
  localparam logic [8:0] E_RS  = 9'b111011_100;
  localparam logic [8:0] E_DI  = 9'b111001_100;
  localparam logic [8:0] E_FLT = 9'b010000_001;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  sel = 0;

  logic clk = 0;
  logic rst_n = 0;
  logic s0 = 0, w0 = 0, a0 = 1;
  logic s1 = 0, w1 = 0, a1 = 1;

  logic pe0, ie0, sv0, rs0, ce0, dr0, by0, as0, ft0;
  logic pe1, ie1, sv1, rs1, ce1, dr1, by1, as1, ft1;

  always #5 clk = ~clk;

  retention_power_controller u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .sleep_req(s0), .wake_req(w0), .pwr_ack(a0),
    .pwr_en(pe0), .iso_en(ie0), .save(sv0),
    .restore(rs0), .clk_en(ce0),
    .domain_rst_n(dr0), .busy(by0),
    .asleep(as0), .fault(ft0)
  );

  retention_power_controller #(
    .SAVE_CYCLES(1), .RESTORE_CYCLES(5),
    .SETTLE_CYCLES(1), .ACK_TIMEOUT(16)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .sleep_req(s1), .wake_req(w1), .pwr_ack(a1),
    .pwr_en(pe1), .iso_en(ie1), .save(sv1),
    .restore(rs1), .clk_en(ce1),
    .domain_rst_n(dr1), .busy(by1),
    .asleep(as1), .fault(ft1)
  );

  wire [8:0] v0 = {pe0, ie0, ce0, sv0, rs0, dr0, by0, as0, ft0};
  wire [8:0] v1 = {pe1, ie1, ce1, sv1, rs1, dr1, by1, as1, ft1};

  // Protocol invariants on both instances.
  always @(negedge clk) begin
    n_cmp = n_cmp + 2;
    assert (!(sv0 && !ce0) && !(sv1 && !ce1)) else begin
      n_bad++;
      $error("FAIL save_clk observed=%b%b expected=00",
             sv0 & ~ce0, sv1 & ~ce1);
    end
    assert (!(rs0 && !(a0 && dr0)) && !(rs1 && !(a1 && dr1))) else begin
      n_bad++;
      $error("FAIL restore_pwr observed=%b%b expected=00",
             rs0 & ~(a0 & dr0), rs1 & ~(a1 & dr1));
    end
  end

  task automatic cyc(
    input logic       r,
    input logic       s,
    input logic       w,
    input logic       a,
    input logic [8:0] e,
    input string      tag
  );
    sb_t        it;
    logic [8:0] got;
    rst_n = r;
    if (sel) begin
      s1 = s; w1 = w; a1 = a;
    end else begin
      s0 = s; w0 = w; a0 = a;
    end
    sb.push_back('{tag: tag, exp: e});
    @(posedge clk);
    #1;
    it  = sb.pop_front();
    got = sel ? v1 : v0;
    n_cmp++;
    assert (got === it.exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", it.tag, got, it.exp);
    end
  endtask

  // RUN -> SLEEP with the ack dropping as soon as power is cut.
  task automatic to_sleep(input int nsave);
    cyc(1, 1, 0, 1, E_ISO, "sl_iso");
    for (int i = 0; i < nsave; i++) cyc(1, 0, 0, 1, E_SAV, "sl_save");
    cyc(1, 0, 0, 1, E_CG, "sl_cg");
    cyc(1, 0, 0, 1, E_PD, "sl_pd");
    cyc(1, 0, 0, 0, E_SLP, "sl_sleep");
  endtask

  // PWR_UP already entered with ack high: default settle/restore.
  task automatic finish_wake();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, E_ST, "wk_settle");
    cyc(1, 0, 0, 1, E_CU, "wk_ungate");
    cyc(1, 0, 0, 1, E_RS, "wk_rest1");
    cyc(1, 0, 0, 1, E_RS, "wk_rest2");
    cyc(1, 0, 0, 1, E_DI, "wk_deiso");
    cyc(1, 0, 0, 1, E_RUN, "wk_run");
  endtask

  initial begin
    sel = 0;
    cyc(0, 0, 0, 1, E_RST, "reset");
    cyc(1, 0, 0, 1, E_RUN, "run_after_reset");
    cyc(1, 0, 1, 1, E_RUN, "run_ignores_wake");

    // Full cycle, ack falls 3 cycles after pwr_en drops.
    cyc(1, 1, 0, 1, E_ISO, "fc_iso");
    cyc(1, 1, 0, 1, E_SAV, "fc_save1");
    cyc(1, 0, 0, 1, E_SAV, "fc_save2");
    cyc(1, 0, 0, 1, E_CG, "fc_cg");
    cyc(1, 0, 0, 1, E_PD, "fc_pd1");
    cyc(1, 0, 0, 1, E_PD, "fc_pd2");
    cyc(1, 0, 0, 1, E_PD, "fc_pd3");
    cyc(1, 0, 0, 0, E_SLP, "fc_sleep");
    cyc(1, 1, 0, 0, E_SLP, "fc_sleep_ign");
    cyc(1, 0, 1, 0, E_PU, "fc_pu1");
    cyc(1, 0, 0, 0, E_PU, "fc_pu2");
    cyc(1, 0, 0, 1, E_ST, "fc_settle1");
    finish_wake();

    // Power-down timeout.
    cyc(1, 1, 0, 1, E_ISO, "pd_iso");
    cyc(1, 0, 0, 1, E_SAV, "pd_save1");
    cyc(1, 0, 0, 1, E_SAV, "pd_save2");
    cyc(1, 0, 0, 1, E_CG, "pd_cg");
    cyc(1, 0, 0, 1, E_PD, "pd_entry");
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 1, E_PD, "pd_wait");
    cyc(1, 0, 0, 1, E_FLT, "pd_fault");
    cyc(1, 1, 0, 1, E_FLT, "pd_fault_hold");
    cyc(1, 0, 1, 1, E_PU, "pd_retry");
    cyc(1, 0, 0, 1, E_ST, "pd_settle1");
    finish_wake();

    // Power-up timeout, then settle glitch.
    to_sleep(2);
    cyc(1, 0, 1, 0, E_PU, "pu_entry");
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, E_PU, "pu_wait");
    cyc(1, 0, 0, 0, E_FLT, "pu_fault");
    cyc(1, 0, 1, 0, E_PU, "gl_pu");
    cyc(1, 0, 0, 1, E_ST, "gl_settle1");
    cyc(1, 0, 0, 1, E_ST, "gl_settle2");
    cyc(1, 0, 0, 0, E_FLT, "gl_fault");
    cyc(1, 0, 1, 1, E_PU, "gl_retry");
    cyc(1, 0, 0, 1, E_ST, "gl_settle1b");
    finish_wake();

    // Mid-sequence requests are ignored.
    cyc(1, 1, 0, 1, E_ISO, "rf_iso");
    cyc(1, 0, 0, 1, E_SAV, "rf_save1");
    cyc(1, 0, 1, 1, E_SAV, "rf_save2_wake");
    cyc(1, 0, 0, 1, E_CG, "rf_cg");
    cyc(1, 0, 0, 1, E_PD, "rf_pd");
    cyc(1, 0, 0, 0, E_SLP, "rf_sleep");
    cyc(1, 0, 1, 0, E_PU, "rf_pu");
    cyc(1, 0, 0, 1, E_ST, "rf_settle1");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, E_ST, "rf_settle");
    cyc(1, 0, 0, 1, E_CU, "rf_ungate");
    cyc(1, 0, 0, 1, E_RS, "rf_rest1");
    cyc(1, 1, 0, 1, E_RS, "rf_rest2_sleep");
    cyc(1, 0, 0, 1, E_DI, "rf_deiso");
    cyc(1, 0, 0, 1, E_RUN, "rf_run");
    cyc(1, 0, 0, 1, E_RUN, "rf_run_stay");

    // Reset in SLEEP and in SAVE.
    to_sleep(2);
    cyc(0, 0, 0, 0, E_RST, "rst_sleep");
    cyc(0, 0, 0, 1, E_RST, "rst_sleep_hold");
    cyc(1, 0, 0, 1, E_RUN, "rst_sleep_rel");
    cyc(1, 1, 0, 1, E_ISO, "rst_iso");
    cyc(1, 0, 0, 1, E_SAV, "rst_save1");
    cyc(0, 0, 0, 1, E_RST, "rst_save");
    cyc(1, 0, 0, 1, E_RUN, "rst_save_rel");

    // Swept instance, sleep held through return to RUN.
    sel = 1;
    cyc(1, 0, 0, 1, E_RUN, "sw_run");
    to_sleep(1);
    cyc(1, 0, 1, 0, E_PU, "sw_pu");
    cyc(1, 0, 0, 1, E_ST, "sw_settle");
    cyc(1, 0, 0, 1, E_CU, "sw_ungate");
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, E_RS, "sw_rest");
    cyc(1, 1, 0, 1, E_RS, "sw_rest5");
    cyc(1, 1, 0, 1, E_DI, "sw_deiso");
    cyc(1, 1, 0, 1, E_RUN, "sw_run_back");
    cyc(1, 1, 0, 1, E_ISO, "sw_reiso");
    cyc(1, 0, 0, 1, E_SAV, "sw_save");
    cyc(1, 0, 0, 1, E_CG, "sw_cg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
